id_branch_fwd_unit: RTL and testbench

- Parametrised ID-stage operand forwarding and hazard unit for branch comparison.
- Computes its own per-operand forward selects from EX/MEM/WB destination info, instead of taking selects as inputs.
- Drives the forwarded Rs/Rt values to the branch comparator.
- Generates deterministic load-use/ALU stalls through a small countdown FSM and keeps saturating stall/forward statistics counters.

---
 rtl/id_branch_fwd_unit_if.sv | 60 ++++++
 rtl/id_branch_fwd_unit.sv | 167 ++++++++++++++++
 tb/tb_id_branch_fwd_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_branch_fwd_unit_if.sv
// Bundle of pipeline-stage status, register operands and forwarding results
// exchanged between the pipeline and the ID-stage branch forwarding unit.
interface id_branch_fwd_unit_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic                  id_is_branch;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;

    logic                  ex_valid;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0]     ex_alu_result;

    logic                  mem_valid;
    logic                  mem_reg_write;
    logic                  mem_mem_read;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0]     mem_result;

    logic                  wb_valid;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;

    logic                  flush;
    logic                  clr_stats;

    logic [DATA_W-1:0]     rd1_out;
    logic [DATA_W-1:0]     rd2_out;
    logic [1:0]            sel_a;
    logic [1:0]            sel_b;
    logic                  stall;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      fwd_events;

    modport master (
        output id_valid, id_is_branch, id_rs, id_rt, rd1, rd2,
        output ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_alu_result,
        output mem_valid, mem_reg_write, mem_mem_read, mem_rd, mem_result,
        output wb_valid, wb_reg_write, wb_rd, wb_data,
        output flush, clr_stats,
        input  rd1_out, rd2_out, sel_a, sel_b, stall, stall_cycles, fwd_events
    );

    modport slave (
        input  id_valid, id_is_branch, id_rs, id_rt, rd1, rd2,
        input  ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_alu_result,
        input  mem_valid, mem_reg_write, mem_mem_read, mem_rd, mem_result,
        input  wb_valid, wb_reg_write, wb_rd, wb_data,
        input  flush, clr_stats,
        output rd1_out, rd2_out, sel_a, sel_b, stall, stall_cycles, fwd_events
    );
endinterface

// File: rtl/id_branch_fwd_unit.sv
// ID-stage operand forwarding and hazard unit for compare-in-ID branches:
// picks forward sources, drives the comparator operands and sequences stalls.
module id_branch_fwd_unit #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int EX_FWD_EN  = 1,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst_n,
    id_branch_fwd_unit_if.slave bus
);

    typedef enum logic {
        IDLE,
        STALL
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stallCycles_q, stallCycles_d;
    logic [CNT_W-1:0] fwdEvents_q, fwdEvents_d;

    logic exHitA, memHitA, wbHitA;
    logic exHitB, memHitB, wbHitB;
    logic [1:0] selA, selB;
    logic [1:0] needA, needB, need;
    logic stall;

    function automatic logic stageHit(input logic v, input logic w,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic [REG_ADDR_W-1:0] src);
        return v && w && (rd == src) && (src != '0);
    endfunction

    // The youngest matching producer owns the operand; if it cannot forward
    // (load, or EX forwarding disabled) older stages must not be used either.
    function automatic logic [1:0] pickSel(input logic exHit, input logic memHit,
                                           input logic wbHit);
        logic [1:0] s;
        s = 2'b00;
        if (exHit) begin
            if (!bus.ex_mem_read && (EX_FWD_EN != 0)) s = 2'b01;
        end else if (memHit) begin
            if (!bus.mem_mem_read) s = 2'b10;
        end else if (wbHit) begin
            s = 2'b11;
        end
        return s;
    endfunction

    function automatic logic [1:0] needOf(input logic exHit, input logic memHit);
        logic [1:0] n;
        n = 2'd0;
        if (exHit) begin
            if (bus.ex_mem_read)      n = 2'd2;
            else if (EX_FWD_EN == 0)  n = 2'd1;
        end else if (memHit && bus.mem_mem_read) begin
            n = 2'd1;
        end
        return n;
    endfunction

    function automatic logic [DATA_W-1:0] muxData(input logic [1:0] s,
                                                  input logic [DATA_W-1:0] regVal);
        logic [DATA_W-1:0] d;
        d = regVal;
        case (s)
            2'b01:   d = bus.ex_alu_result;
            2'b10:   d = bus.mem_result;
            2'b11:   d = bus.wb_data;
            default: d = regVal;
        endcase
        return d;
    endfunction

    always_comb begin
        exHitA  = stageHit(bus.ex_valid,  bus.ex_reg_write,  bus.ex_rd,  bus.id_rs);
        memHitA = stageHit(bus.mem_valid, bus.mem_reg_write, bus.mem_rd, bus.id_rs);
        wbHitA  = stageHit(bus.wb_valid,  bus.wb_reg_write,  bus.wb_rd,  bus.id_rs);
        exHitB  = stageHit(bus.ex_valid,  bus.ex_reg_write,  bus.ex_rd,  bus.id_rt);
        memHitB = stageHit(bus.mem_valid, bus.mem_reg_write, bus.mem_rd, bus.id_rt);
        wbHitB  = stageHit(bus.wb_valid,  bus.wb_reg_write,  bus.wb_rd,  bus.id_rt);
        selA    = pickSel(exHitA, memHitA, wbHitA);
        selB    = pickSel(exHitB, memHitB, wbHitB);
        needA   = needOf(exHitA, memHitA);
        needB   = needOf(exHitB, memHitB);
        need    = 2'd0;
        if (bus.id_valid && bus.id_is_branch) begin
            need = (needA > needB) ? needA : needB;
        end
    end

    // Only a two-cycle load hazard needs the countdown state; single-cycle
    // hazards clear themselves once the pipeline advances.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    stall = (need != 2'd0);
                    if (need == 2'd2) begin
                        state_d = STALL;
                        cnt_d   = 2'd1;
                    end
                end
                STALL: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        stallCycles_d = stallCycles_q;
        fwdEvents_d   = fwdEvents_q;
        if (bus.clr_stats) begin
            stallCycles_d = '0;
            fwdEvents_d   = '0;
        end else begin
            if (stall && !(&stallCycles_q)) begin
                stallCycles_d = stallCycles_q + 1'b1;
            end
            if (!stall && bus.id_valid && bus.id_is_branch &&
                ((selA != 2'b00) || (selB != 2'b00)) && !(&fwdEvents_q)) begin
                fwdEvents_d = fwdEvents_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            stallCycles_q <= '0;
            fwdEvents_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stallCycles_q <= stallCycles_d;
            fwdEvents_q   <= fwdEvents_d;
        end
    end

    assign bus.sel_a        = selA;
    assign bus.sel_b        = selB;
    assign bus.rd1_out      = muxData(selA, bus.rd1);
    assign bus.rd2_out      = muxData(selB, bus.rd2);
    assign bus.stall        = stall;
    assign bus.stall_cycles = stallCycles_q;
    assign bus.fwd_events   = fwdEvents_q;

endmodule

// File: tb/tb_id_branch_fwd_unit.sv
// Directed bench for id_branch_fwd_unit: default build, an EX-forwarding-disabled
// build and a narrow-counter build all see the same stimulus.
module tb_id_branch_fwd_unit;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;

    id_branch_fwd_unit_if #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(16)) busA ();
    id_branch_fwd_unit_if #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(16)) busB ();
    id_branch_fwd_unit_if #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(4))  busC ();

    id_branch_fwd_unit #(.DATA_W(16), .REG_ADDR_W(3), .EX_FWD_EN(1), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA.slave));
    id_branch_fwd_unit #(.DATA_W(16), .REG_ADDR_W(3), .EX_FWD_EN(0), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB.slave));
    id_branch_fwd_unit #(.DATA_W(16), .REG_ADDR_W(3), .EX_FWD_EN(1), .CNT_W(4)) dutC (
        .clk(clk), .rst_n(rst_n), .bus(busC.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The two variant builds mirror whatever is driven onto busA.
    always_comb begin
        busB.id_valid      = busA.id_valid;      busC.id_valid      = busA.id_valid;
        busB.id_is_branch  = busA.id_is_branch;  busC.id_is_branch  = busA.id_is_branch;
        busB.id_rs         = busA.id_rs;         busC.id_rs         = busA.id_rs;
        busB.id_rt         = busA.id_rt;         busC.id_rt         = busA.id_rt;
        busB.rd1           = busA.rd1;           busC.rd1           = busA.rd1;
        busB.rd2           = busA.rd2;           busC.rd2           = busA.rd2;
        busB.ex_valid      = busA.ex_valid;      busC.ex_valid      = busA.ex_valid;
        busB.ex_reg_write  = busA.ex_reg_write;  busC.ex_reg_write  = busA.ex_reg_write;
        busB.ex_mem_read   = busA.ex_mem_read;   busC.ex_mem_read   = busA.ex_mem_read;
        busB.ex_rd         = busA.ex_rd;         busC.ex_rd         = busA.ex_rd;
        busB.ex_alu_result = busA.ex_alu_result; busC.ex_alu_result = busA.ex_alu_result;
        busB.mem_valid     = busA.mem_valid;     busC.mem_valid     = busA.mem_valid;
        busB.mem_reg_write = busA.mem_reg_write; busC.mem_reg_write = busA.mem_reg_write;
        busB.mem_mem_read  = busA.mem_mem_read;  busC.mem_mem_read  = busA.mem_mem_read;
        busB.mem_rd        = busA.mem_rd;        busC.mem_rd        = busA.mem_rd;
        busB.mem_result    = busA.mem_result;    busC.mem_result    = busA.mem_result;
        busB.wb_valid      = busA.wb_valid;      busC.wb_valid      = busA.wb_valid;
        busB.wb_reg_write  = busA.wb_reg_write;  busC.wb_reg_write  = busA.wb_reg_write;
        busB.wb_rd         = busA.wb_rd;         busC.wb_rd         = busA.wb_rd;
        busB.wb_data       = busA.wb_data;       busC.wb_data       = busA.wb_data;
        busB.flush         = busA.flush;         busC.flush         = busA.flush;
        busB.clr_stats     = busA.clr_stats;     busC.clr_stats     = busA.clr_stats;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        busA.id_valid = 1'b0;  busA.id_is_branch = 1'b0;
        busA.id_rs = 3'd0;     busA.id_rt = 3'd0;
        busA.rd1 = 16'hAAAA;   busA.rd2 = 16'hBBBB;
        busA.ex_valid = 1'b0;  busA.ex_reg_write = 1'b0;  busA.ex_mem_read = 1'b0;
        busA.ex_rd = 3'd0;     busA.ex_alu_result = 16'h0;
        busA.mem_valid = 1'b0; busA.mem_reg_write = 1'b0; busA.mem_mem_read = 1'b0;
        busA.mem_rd = 3'd0;    busA.mem_result = 16'h0;
        busA.wb_valid = 1'b0;  busA.wb_reg_write = 1'b0;
        busA.wb_rd = 3'd0;     busA.wb_data = 16'h0;
        busA.flush = 1'b0;     busA.clr_stats = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] rs, input logic [2:0] rt);
        busA.id_valid = 1'b1; busA.id_is_branch = 1'b1;
        busA.id_rs = rs;      busA.id_rt = rt;
    endtask

    task automatic clearStats();
        clearInputs();
        busA.clr_stats = 1'b1;
        tick();
        busA.clr_stats = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        clearInputs();
        #3;
        checkOutput("reset_stall", {31'd0, busA.stall}, 32'd0);
        checkOutput("reset_sel_a", {30'd0, busA.sel_a}, 32'd0);
        checkOutput("reset_rd1_out", {16'd0, busA.rd1_out}, 32'h0000AAAA);
        checkOutput("reset_rd2_out", {16'd0, busA.rd2_out}, 32'h0000BBBB);
        checkOutput("reset_stall_cycles", {16'd0, busA.stall_cycles}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Forward priority EX > MEM > WB on rs = r3
        applyStimulus(3'd3, 3'd0);
        busA.ex_valid = 1'b1;  busA.ex_reg_write = 1'b1;  busA.ex_rd = 3'd3;  busA.ex_alu_result = 16'h1111;
        busA.mem_valid = 1'b1; busA.mem_reg_write = 1'b1; busA.mem_rd = 3'd3; busA.mem_result = 16'h2222;
        busA.wb_valid = 1'b1;  busA.wb_reg_write = 1'b1;  busA.wb_rd = 3'd3;  busA.wb_data = 16'h3333;
        #2;
        checkOutput("prio_ex_sel_a", {30'd0, busA.sel_a}, 32'd1);
        checkOutput("prio_ex_rd1_out", {16'd0, busA.rd1_out}, 32'h00001111);
        checkOutput("prio_ex_stall", {31'd0, busA.stall}, 32'd0);
        checkOutput("prio_ex_sel_b", {30'd0, busA.sel_b}, 32'd0);
        checkOutput("prio_ex_rd2_out", {16'd0, busA.rd2_out}, 32'h0000BBBB);
        checkOutput("noexfwd_stall", {31'd0, busB.stall}, 32'd1);
        checkOutput("noexfwd_sel_a", {30'd0, busB.sel_a}, 32'd0);
        tick();
        checkOutput("prio_ex_fwd_events", {16'd0, busA.fwd_events}, 32'd1);
        busA.ex_valid = 1'b0;
        #2;
        checkOutput("prio_mem_sel_a", {30'd0, busA.sel_a}, 32'd2);
        checkOutput("prio_mem_rd1_out", {16'd0, busA.rd1_out}, 32'h00002222);
        checkOutput("noexfwd_mem_sel_a", {30'd0, busB.sel_a}, 32'd2);
        checkOutput("noexfwd_mem_stall", {31'd0, busB.stall}, 32'd0);
        checkOutput("noexfwd_stall_cycles", {16'd0, busB.stall_cycles}, 32'd1);
        tick();
        checkOutput("prio_mem_fwd_events", {16'd0, busA.fwd_events}, 32'd2);
        busA.mem_valid = 1'b0;
        #2;
        checkOutput("prio_wb_sel_a", {30'd0, busA.sel_a}, 32'd3);
        checkOutput("prio_wb_rd1_out", {16'd0, busA.rd1_out}, 32'h00003333);

        // Load in EX on rt = r5: two stall cycles, then WB forward
        clearStats();
        #2;
        checkOutput("clr_fwd_events", {16'd0, busA.fwd_events}, 32'd0);
        applyStimulus(3'd1, 3'd5);
        busA.ex_valid = 1'b1; busA.ex_reg_write = 1'b1; busA.ex_mem_read = 1'b1; busA.ex_rd = 3'd5;
        #2;
        checkOutput("ldex_c1_stall", {31'd0, busA.stall}, 32'd1);
        checkOutput("ldex_c1_sel_b", {30'd0, busA.sel_b}, 32'd0);
        tick();
        busA.ex_valid = 1'b0; busA.ex_mem_read = 1'b0;
        busA.mem_valid = 1'b1; busA.mem_reg_write = 1'b1; busA.mem_mem_read = 1'b1; busA.mem_rd = 3'd5;
        #2;
        checkOutput("ldex_c2_stall", {31'd0, busA.stall}, 32'd1);
        tick();
        busA.mem_valid = 1'b0; busA.mem_mem_read = 1'b0;
        busA.wb_valid = 1'b1; busA.wb_reg_write = 1'b1; busA.wb_rd = 3'd5; busA.wb_data = 16'h5A5A;
        #2;
        checkOutput("ldex_c3_stall", {31'd0, busA.stall}, 32'd0);
        checkOutput("ldex_c3_sel_b", {30'd0, busA.sel_b}, 32'd3);
        checkOutput("ldex_c3_rd2_out", {16'd0, busA.rd2_out}, 32'h00005A5A);
        checkOutput("ldex_stall_cycles", {16'd0, busA.stall_cycles}, 32'd2);
        tick();
        checkOutput("ldex_fwd_events", {16'd0, busA.fwd_events}, 32'd1);

        // Load in MEM on rs with ALU in EX on rt: one stall cycle
        clearStats();
        applyStimulus(3'd2, 3'd4);
        busA.mem_valid = 1'b1; busA.mem_reg_write = 1'b1; busA.mem_mem_read = 1'b1; busA.mem_rd = 3'd2;
        busA.ex_valid = 1'b1;  busA.ex_reg_write = 1'b1;  busA.ex_rd = 3'd4; busA.ex_alu_result = 16'h4444;
        #2;
        checkOutput("ldmem_c1_stall", {31'd0, busA.stall}, 32'd1);
        checkOutput("ldmem_c1_sel_b", {30'd0, busA.sel_b}, 32'd1);
        tick();
        busA.ex_valid = 1'b0;
        busA.mem_mem_read = 1'b0; busA.mem_rd = 3'd4; busA.mem_result = 16'h4444;
        busA.wb_valid = 1'b1; busA.wb_reg_write = 1'b1; busA.wb_rd = 3'd2; busA.wb_data = 16'h2B2B;
        #2;
        checkOutput("ldmem_c2_stall", {31'd0, busA.stall}, 32'd0);
        checkOutput("ldmem_c2_sel_a", {30'd0, busA.sel_a}, 32'd3);
        checkOutput("ldmem_c2_rd1_out", {16'd0, busA.rd1_out}, 32'h00002B2B);
        checkOutput("ldmem_c2_sel_b", {30'd0, busA.sel_b}, 32'd2);
        checkOutput("ldmem_c2_rd2_out", {16'd0, busA.rd2_out}, 32'h00004444);
        checkOutput("ldmem_stall_cycles", {16'd0, busA.stall_cycles}, 32'd1);

        // Register 0 is never forwarded and never stalls
        clearStats();
        applyStimulus(3'd0, 3'd0);
        busA.ex_valid = 1'b1;  busA.ex_reg_write = 1'b1;  busA.ex_mem_read = 1'b1; busA.ex_rd = 3'd0;
        busA.mem_valid = 1'b1; busA.mem_reg_write = 1'b1; busA.mem_rd = 3'd0;
        busA.wb_valid = 1'b1;  busA.wb_reg_write = 1'b1;  busA.wb_rd = 3'd0;
        #2;
        checkOutput("r0_sel_a", {30'd0, busA.sel_a}, 32'd0);
        checkOutput("r0_sel_b", {30'd0, busA.sel_b}, 32'd0);
        checkOutput("r0_rd1_out", {16'd0, busA.rd1_out}, 32'h0000AAAA);
        checkOutput("r0_rd2_out", {16'd0, busA.rd2_out}, 32'h0000BBBB);
        checkOutput("r0_stall", {31'd0, busA.stall}, 32'd0);
        tick();
        checkOutput("r0_stall_cycles", {16'd0, busA.stall_cycles}, 32'd0);
        checkOutput("r0_fwd_events", {16'd0, busA.fwd_events}, 32'd0);

        // Flush on the second cycle of a load stall
        clearStats();
        applyStimulus(3'd1, 3'd5);
        busA.ex_valid = 1'b1; busA.ex_reg_write = 1'b1; busA.ex_mem_read = 1'b1; busA.ex_rd = 3'd5;
        #2;
        checkOutput("flush_c1_stall", {31'd0, busA.stall}, 32'd1);
        tick();
        busA.ex_valid = 1'b0; busA.ex_mem_read = 1'b0;
        busA.mem_valid = 1'b1; busA.mem_reg_write = 1'b1; busA.mem_mem_read = 1'b1; busA.mem_rd = 3'd5;
        busA.flush = 1'b1;
        #2;
        checkOutput("flush_c2_stall", {31'd0, busA.stall}, 32'd0);
        tick();
        clearInputs();
        #2;
        checkOutput("flush_c3_stall", {31'd0, busA.stall}, 32'd0);
        checkOutput("flush_stall_cycles", {16'd0, busA.stall_cycles}, 32'd1);

        // Asynchronous reset while in the STALL state
        applyStimulus(3'd1, 3'd5);
        busA.ex_valid = 1'b1; busA.ex_reg_write = 1'b1; busA.ex_mem_read = 1'b1; busA.ex_rd = 3'd5;
        tick();
        #1;
        checkOutput("rst_pre_stall", {31'd0, busA.stall}, 32'd1);
        checkOutput("rst_pre_stall_cycles", {16'd0, busA.stall_cycles}, 32'd2);
        busA.id_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_stall", {31'd0, busA.stall}, 32'd0);
        checkOutput("rst_mid_stall_cycles", {16'd0, busA.stall_cycles}, 32'd0);
        #1;
        rst_n = 1'b1;
        clearInputs();
        tick();
        checkOutput("rst_post_stall", {31'd0, busA.stall}, 32'd0);

        // Saturation of the 4-bit counter build, then clear during a stall
        clearStats();
        applyStimulus(3'd2, 3'd0);
        busA.mem_valid = 1'b1; busA.mem_reg_write = 1'b1; busA.mem_mem_read = 1'b1; busA.mem_rd = 3'd2;
        for (int i = 0; i < 20; i++) tick();
        #1;
        checkOutput("sat_stall", {31'd0, busC.stall}, 32'd1);
        checkOutput("sat_stall_cycles_c", {28'd0, busC.stall_cycles}, 32'd15);
        checkOutput("sat_stall_cycles_a", {16'd0, busA.stall_cycles}, 32'd20);
        busA.clr_stats = 1'b1;
        tick();
        checkOutput("sat_clr_stall_cycles", {28'd0, busC.stall_cycles}, 32'd0);
        busA.clr_stats = 1'b0;
        tick();
        checkOutput("sat_restart_stall_cycles", {28'd0, busC.stall_cycles}, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
